// File: rtl/scenery_scheduler.sv
// scenery_scheduler
//
// Frame-driven controller for the roadside scenery. Four slots are spawned at the
// top of the screen at pseudo-random verge positions. Each slot scrolls down at road
// speed and is retired once it passes the bottom of the screen. A level-up request
// first drains the screen. It then toggles newLevel, which switches background_mux
// between the tree/house set and the cactus/rock set.
//
// Ports:
//   clk           system clock
//   resetN        synchronous, active-low reset
//   startOfFrame  one-cycle pulse per video frame
//   speed[3:0]    unsigned scroll step, pixels per frame
//   pause         freezes all frame activity (scroll, timers, LFSR)
//   levelUpReq    one-cycle level-change request (honoured only in RUN)
//   newLevel      0 = trees/houses, 1 = cactus/rocks
//   levelAck      one-cycle pulse when a level swap completes
//   slotActive    per-slot drawing enable
//   slotX         per-slot unsigned top-left X
//   slotY         per-slot signed top-left Y (11-bit two's complement)

module scenery_scheduler #(
    parameter int          SCREEN_H          = 480,
    parameter int          SPAWN_Y           = -64,
    parameter int          SPAWN_INTERVAL    = 32,
    parameter int          TRANSITION_FRAMES = 64,
    parameter int          LEFT_X            = 8,
    parameter int          RIGHT_X           = 560,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic [3:0]       speed,
    input  logic             pause,
    input  logic             levelUpReq,
    output logic             newLevel,
    output logic             levelAck,
    output logic [3:0]       slotActive,
    output logic [3:0][10:0] slotX,
    output logic [3:0][10:0] slotY
);

    localparam int TimerW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int DrainW = (TRANSITION_FRAMES > 1) ? $clog2(TRANSITION_FRAMES) : 1;

    localparam logic [TimerW-1:0]  TimerLast = TimerW'(SPAWN_INTERVAL - 1);
    localparam logic [DrainW-1:0]  DrainLast = DrainW'(TRANSITION_FRAMES - 1);
    localparam logic signed [10:0] ScreenH   = 11'(SCREEN_H);
    localparam logic [10:0]        SpawnY    = 11'(SPAWN_Y);
    localparam logic [10:0]        LeftX     = 11'(LEFT_X);
    localparam logic [10:0]        RightX    = 11'(RIGHT_X);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StSwap
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [TimerW-1:0] spawn_timer_q, spawn_timer_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic              new_level_d;
    logic              level_ack_d;
    logic [3:0]        active_d;
    logic [3:0][10:0]  x_d;
    logic [3:0][10:0]  y_d;

    logic              frame_evt;
    logic              lfsr_fb;
    logic [3:0]        scr_active;
    logic [3:0][10:0]  scr_y;
    logic              free_found;
    logic [1:0]        free_idx;
    logic [10:0]       spawn_x;

    // pause masks the frame pulse completely, so nothing below ever sees it
    assign frame_evt = startOfFrame & ~pause;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Scrolled view of the slots for this frame, with retirements already applied.
    always_comb begin
        scr_active = slotActive;
        scr_y      = slotY;
        for (int i = 0; i < 4; i++) begin
            if (slotActive[i]) begin
                scr_y[i] = slotY[i] + {7'd0, speed};
                if ($signed(scr_y[i]) >= ScreenH) begin
                    scr_active[i] = 1'b0;
                end
            end
        end
    end

    // Lowest-index slot that is free after this frame's retirements.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!scr_active[i]) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end
    end

    // Spawn position uses the LFSR value held before this frame's step.
    assign spawn_x = (free_idx[0] ? RightX : LeftX) + {5'd0, lfsr_q[5:0]};

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        spawn_timer_d = spawn_timer_q;
        drain_cnt_d   = drain_cnt_q;
        new_level_d   = newLevel;
        level_ack_d   = 1'b0;
        active_d      = slotActive;
        x_d           = slotX;
        y_d           = slotY;

        if (frame_evt) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end

        unique case (state_q)
            StRun: begin
                if (frame_evt) begin
                    active_d = scr_active;
                    y_d      = scr_y;
                    if (spawn_timer_q == TimerLast) begin
                        // With no free slot the timer parks here and retries next frame.
                        if (free_found) begin
                            active_d[free_idx] = 1'b1;
                            x_d[free_idx]      = spawn_x;
                            y_d[free_idx]      = SpawnY;
                            spawn_timer_d      = '0;
                        end
                    end else begin
                        spawn_timer_d = spawn_timer_q + TimerW'(1);
                    end
                end
                // A request arriving with a frame event still gets the RUN update above.
                if (levelUpReq) begin
                    state_d = StDrain;
                end
            end

            StDrain: begin
                if (frame_evt) begin
                    active_d = scr_active;
                    y_d      = scr_y;
                    if (scr_active == 4'b0000) begin
                        state_d = StSwap;
                    end else if (drain_cnt_q == DrainLast) begin
                        // Timed out: drop whatever is still on screen.
                        active_d = 4'b0000;
                        state_d  = StSwap;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DrainW'(1);
                    end
                end
            end

            StSwap: begin
                new_level_d   = ~newLevel;
                level_ack_d   = 1'b1;
                spawn_timer_d = '0;
                drain_cnt_d   = '0;
                state_d       = StRun;
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= StRun;
            lfsr_q        <= LFSR_SEED;
            spawn_timer_q <= '0;
            drain_cnt_q   <= '0;
            newLevel      <= 1'b0;
            levelAck      <= 1'b0;
            slotActive    <= '0;
            slotX         <= '0;
            slotY         <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            spawn_timer_q <= spawn_timer_d;
            drain_cnt_q   <= drain_cnt_d;
            newLevel      <= new_level_d;
            levelAck      <= level_ack_d;
            slotActive    <= active_d;
            slotX         <= x_d;
            slotY         <= y_d;
        end
    end

endmodule

// File: doc/scenery_scheduler.md
# scenery_scheduler

Frame-driven controller that sequences the roadside scenery objects and the level set selected by `background_mux`. It owns four scenery slots: spawns them at the top of the screen at pseudo-random verge positions, scrolls them with road speed, and retires them at the bottom. On a level-up request it drains the screen, then toggles `newLevel` to switch between the tree/house set and the cactus/rock set. Its outputs drive the object position generators and `background_mux.newLevel`.

## Interface
- `SCREEN_H`, 480 — retire threshold on Y, in pixels.
- `SPAWN_Y`, -64 — signed Y loaded into a slot when it spawns.
- `SPAWN_INTERVAL`, 32 — frames between spawn attempts; must be ≥1.
- `TRANSITION_FRAMES`, 64 — maximum frames spent in DRAIN.
- `LEFT_X`, 8 — X base for even slots.
- `RIGHT_X`, 560 — X base for odd slots.
- `LFSR_SEED`, 16'hACE1 — LFSR reset value; must be nonzero.
- `clk` in 1 — system clock.
- `resetN` in 1 — reset, synchronous, active-low.
- `startOfFrame` in 1 — one-cycle pulse per video frame.
- `speed` in 4 — unsigned scroll, in pixels per frame.
- `pause` in 1 — freezes all frame activity.
- `levelUpReq` in 1 — one-cycle level-change request.
- `newLevel` out 1 — 0 selects trees/houses, 1 selects cactus/rocks.
- `levelAck` out 1 — one-cycle pulse when a level swap completes.
- `slotActive` out 4 — per-slot drawing enable.
- `slotX` out [3:0][10:0] — unsigned top-left X per slot.
- `slotY` out [3:0][10:0] — signed top-left Y per slot.

## Operation
- A "frame event" is `startOfFrame`=1 and `pause`=0. While `pause`=1, `startOfFrame` is ignored entirely: no scroll, no timers, no LFSR step.
- LFSR (16-bit Fibonacci):
  - Next value is `{lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - It steps once per frame event.
  - A spawn uses the value held before that frame's step.
- Per frame event, for each active slot:
  - Y ← Y + zero-extended `speed`, computed as 11-bit signed.
  - If the new Y ≥ `SCREEN_H` (signed compare), the slot deactivates in the same update.
- Spawn, in RUN only:
  - `spawnTimer` increments per frame event.
  - When `spawnTimer` = `SPAWN_INTERVAL`-1 and a free slot exists, the lowest-index free slot activates. Free means free after this frame's retirements.
  - The spawned slot gets Y=`SPAWN_Y` and X = base + `lfsr[5:0]`. Base is `LEFT_X` for even slots, `RIGHT_X` for odd slots.
  - `spawnTimer` then returns to 0.
  - If no slot is free, `spawnTimer` holds at `SPAWN_INTERVAL`-1 and retries every frame event.
- FSM states:
  - RUN: scroll and spawn. `levelUpReq`=1 → DRAIN next cycle.
  - DRAIN: scroll only, no spawns. `drainCnt` increments per frame event. Go to SWAP when all slots are inactive, or on the frame event where `drainCnt` = `TRANSITION_FRAMES`-1. In the timeout case, all slots are cleared.
  - SWAP: lasts 1 clock. Toggle `newLevel`, pulse `levelAck`, clear `spawnTimer` and `drainCnt` → RUN.
- `levelUpReq` in DRAIN or SWAP is ignored; requests are not queued.
- Simultaneous `levelUpReq` and frame event in RUN: the frame update runs as RUN (a spawn is allowed), then the state becomes DRAIN.

## Timing
- All outputs are registered. Updates happen on the edge sampling a frame event and are visible the following cycle.
- RUN→DRAIN takes 1 cycle after `levelUpReq`.
- DRAIN→SWAP happens on the edge of the qualifying frame event. `newLevel` toggles and `levelAck`=1 in the cycle after SWAP; `levelAck` lasts exactly 1 cycle.
- Reset values:
  - `newLevel`=0, `levelAck`=0, `slotActive`=0, `slotX`=0, `slotY`=0.
  - `state`=RUN, `spawnTimer`=0, `drainCnt`=0, LFSR=`LFSR_SEED`.
- `resetN` has priority over every event, including reset during DRAIN or SWAP. `newLevel` returns to 0.

## Test plan
- Reset: hold `resetN`=0 across frame pulses → all outputs at reset values, LFSR = 16'hACE1, no spawn.
- First spawn (`SPAWN_INTERVAL`=1, `speed`=0): first frame event → `slotActive`=4'b0001, `slotX[0]`=41 (8+0x21), `slotY[0]`=-64. Second event → slot1 active with `slotX[1]` = 560 + stepped `lfsr[5:0]`, checked against the model.
- Scroll/retire (`speed`=15, single slot): after 36 frames Y=476 and the slot is active; at frame 37 Y would be 491, so `slotActive[0]`→0.
- Full: 4 active slots with the timer at the interval → no spawn and the timer holds. On the frame slot 2 retires, slot 2 respawns at Y=-64 in the same update.
- Level drain: `levelUpReq` with 2 active slots → no further spawns. After the last retire: `newLevel` 0→1, `levelAck` high 1 cycle, spawning resumes. A second `levelUpReq` mid-DRAIN is ignored.
- Timeout/pause/reset: `speed`=0 and `levelUpReq` → SWAP after exactly 64 frame events, slots cleared. `pause`=1 → outputs and LFSR frozen. `resetN`=0 in DRAIN → RUN, `newLevel`=0.
